pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
Cycle-level sequencer for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
- Takes the ID-stage control decode plus EX/MEM/WB destination info and the data-memory ready handshake.
- Drives PC/IF-ID enables, ID/EX bubble insertion, the IF flush on taken branches, and the operand forwarding selects.
- Owns the load-use stall and memory-wait state machine, so pipeline registers stay simple enable/clear flops.

Parameters:
- LOAD_USE_BUBBLES, 1, number of bubbles inserted on a load-use hazard (1..3).
- MEM_TIMEOUT, 15, maximum consecutive wait cycles on mem_ready before mem_error pulses.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- ID_Rn, ID_Rm, ID_Rd  in  4 each  ID-stage source register fields; ID_Rd is the store-data source.
- ID_use_Rn, ID_use_Rm, ID_use_Rd  in  1 each  the corresponding source is actually read.
- ID_B_instr  in  1  branch decoded in ID.
- cond_true  in  1  branch condition evaluated true.
- EX_Rd, MEM_Rd, WB_Rd  in  4 each  destination register of each stage.
- EX_RF_enable, MEM_RF_enable, WB_RF_enable  in  1 each  the stage writes the register file.
- EX_Load_Inst  in  1  EX instruction is a load.
- MEM_mem_enable  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory access is complete this cycle.
- PC_enable  out  1  PC register load enable.
- IF_ID_enable  out  1  IF/ID register load enable.
- ID_nop_sel  out  1  replace ID/EX control with NOP.
- IF_flush  out  1  clear IF/ID (squash the wrong-path fetch).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_A, fwd_B, fwd_C  out  2 each  forward select for Rn, Rm and Rd: 00 RF, 01 EX, 10 MEM, 11 WB.
- mem_error  out  1  one-cycle timeout pulse.

Behaviour:
- State register with states RUN, LOAD_STALL, MEM_WAIT. The state, bubble counter (2b) and wait counter (ceil log2(MEM_TIMEOUT+1) bits) are updated on the clk posedge.
- Reset (sync): state goes to RUN and both counters clear. While reset is high, outputs are forced to:
  - PC_enable=0, IF_ID_enable=0, ID_nop_sel=1, IF_flush=1;
  - pipe_freeze=0, fwd_*=00, mem_error=0.
- Reset mid-operation aborts any stall or wait immediately. There is no residual bubble after release.
- Forwarding (combinational, all states):
  - For each used source register R, with R != 15, priority is:
    - EX, if EX_RF_enable and EX_Rd==R and !EX_Load_Inst;
    - else MEM, if MEM_RF_enable and MEM_Rd==R;
    - else WB, if WB_RF_enable and WB_Rd==R;
    - else 00.
  - An unused source or R15 always gives 00.
- Load-use hazard (luh): any used source R != 15 equals EX_Rd, with EX_RF_enable=1 and EX_Load_Inst=1.
- Memory wait (mw): MEM_mem_enable=1 and mem_ready=0.
- Event priority: mw > luh > taken branch.
- RUN:
  - If mw: pipe_freeze=1, PC_enable=0, IF_ID_enable=0, ID_nop_sel=0; wait counter goes to 1; next state MEM_WAIT.
  - Else if luh: PC_enable=0, IF_ID_enable=0, ID_nop_sel=1; bubble counter goes to 1; next state is LOAD_STALL if LOAD_USE_BUBBLES>1, else RUN.
  - Else if ID_B_instr and cond_true: IF_flush=1 for this cycle; PC and IF/ID stay enabled.
  - Else all enables are 1 and the other controls are 0.
- LOAD_STALL:
  - Same outputs as the luh case; the bubble counter increments.
  - Return to RUN once the counter equals LOAD_USE_BUBBLES.
  - An mw arising in this state takes priority and moves to MEM_WAIT.
- MEM_WAIT:
  - Outputs freeze (as in the mw case) while mem_ready=0; the wait counter increments each cycle.
  - On mem_ready=1 the freeze drops in that same cycle, the counter clears, and the state returns to RUN.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_error=1 for exactly one cycle, the counter clears, and the state forces to RUN. The freeze releases and the faulted access is dropped.
- A taken branch held during a stall is not flushed until the stall ends. The branch is re-evaluated from the held ID contents, so exactly one IF_flush pulse occurs per branch.
- The ID-stage NOP (all-zero instruction) has all ID_use_* = 0, so it never causes a hazard.

Test Plan:
- Reset held for 3 cycles, then released -> during reset PC_enable=0, ID_nop_sel=1, IF_flush=1; first cycle after release is RUN with PC_enable=1, outputs clean.
- EX_Rd=3 with EX_RF_enable=1, MEM_Rd=3 with MEM_RF_enable=1, ID_Rn=3 used -> fwd_A=01. Then EX_Load_Inst=1 -> fwd_A=10 and a luh stall: PC_enable=0, ID_nop_sel=1 for exactly 1 cycle (default bubbles).
- LOAD_USE_BUBBLES=2 with a luh on R5 -> exactly 2 bubble cycles, then PC_enable=1.
- MEM_mem_enable=1 with mem_ready low for 4 cycles -> pipe_freeze=1 for those 4 cycles, 0 in the mem_ready cycle, mem_error stays 0. With mem_ready held low for 15 cycles -> one mem_error pulse, then the state is RUN.
- ID_B_instr=1 with cond_true=1 in RUN -> IF_flush=1 for 1 cycle. The same branch together with a simultaneous luh -> stall first, then a single IF_flush on the following cycle.
- ID_Rm=15 used, with EX_Rd=15 and EX_RF_enable=1 -> fwd_B=00 and no stall.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard sequencer for the 5-stage pipeline. It generates the forwarding selects, load-use bubbles,
// data-memory wait/timeout freezes and the taken-branch IF flush.
module pipeline_hazard_sequencer #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ID_Rn,
    input  logic [3:0] ID_Rm,
    input  logic [3:0] ID_Rd,
    input  logic       ID_use_Rn,
    input  logic       ID_use_Rm,
    input  logic       ID_use_Rd,
    input  logic       ID_B_instr,
    input  logic       cond_true,
    input  logic [3:0] EX_Rd,
    input  logic [3:0] MEM_Rd,
    input  logic [3:0] WB_Rd,
    input  logic       EX_RF_enable,
    input  logic       MEM_RF_enable,
    input  logic       WB_RF_enable,
    input  logic       EX_Load_Inst,
    input  logic       MEM_mem_enable,
    input  logic       mem_ready,
    output logic       PC_enable,
    output logic       IF_ID_enable,
    output logic       ID_nop_sel,
    output logic       IF_flush,
    output logic       pipe_freeze,
    output logic [1:0] fwd_A,
    output logic [1:0] fwd_B,
    output logic [1:0] fwd_C,
    output logic       mem_error
);

    localparam int            WW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]    BUBBLES  = 2'(LOAD_USE_BUBBLES);
    localparam logic [WW-1:0] TIMEOUT  = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    state_t        state, state_next;
    logic [1:0]    bub_cnt, bub_next, bub_inc;
    logic [WW-1:0] wait_cnt, wait_next, wait_inc;
    logic          mw, luh, branch_taken;
    logic          run_eval, mw_allowed;

    function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic use_r,
                                          input logic [3:0] ex_rd, input logic ex_we,
                                          input logic ex_load, input logic [3:0] mem_rd,
                                          input logic mem_we, input logic [3:0] wb_rd,
                                          input logic wb_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r && r != 4'd15) begin
            if (ex_we && ex_rd == r && !ex_load)
                sel = 2'b01;
            else if (mem_we && mem_rd == r)
                sel = 2'b10;
            else if (wb_we && wb_rd == r)
                sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic load_hit(input logic [3:0] r, input logic use_r,
                                      input logic [3:0] ex_rd, input logic ex_we,
                                      input logic ex_load);
        return use_r && r != 4'd15 && ex_we && ex_load && ex_rd == r;
    endfunction

    assign fwd_A = reset ? 2'b00 : fwd_sel(ID_Rn, ID_use_Rn, EX_Rd, EX_RF_enable, EX_Load_Inst,
                                           MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
    assign fwd_B = reset ? 2'b00 : fwd_sel(ID_Rm, ID_use_Rm, EX_Rd, EX_RF_enable, EX_Load_Inst,
                                           MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
    assign fwd_C = reset ? 2'b00 : fwd_sel(ID_Rd, ID_use_Rd, EX_Rd, EX_RF_enable, EX_Load_Inst,
                                           MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);

    assign luh = load_hit(ID_Rn, ID_use_Rn, EX_Rd, EX_RF_enable, EX_Load_Inst) ||
                 load_hit(ID_Rm, ID_use_Rm, EX_Rd, EX_RF_enable, EX_Load_Inst) ||
                 load_hit(ID_Rd, ID_use_Rd, EX_Rd, EX_RF_enable, EX_Load_Inst);
    assign mw           = MEM_mem_enable && !mem_ready;
    assign branch_taken = ID_B_instr && cond_true;
    assign bub_inc      = bub_cnt + 2'd1;
    assign wait_inc     = wait_cnt + WW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            bub_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            bub_cnt  <= bub_next;
            wait_cnt <= wait_next;
        end
    end

    // A wait release or timeout falls through to the normal RUN decision in the same cycle,
    // so a held branch or load-use hazard is handled without losing a cycle.
    always_comb begin
        state_next   = state;
        bub_next     = bub_cnt;
        wait_next    = wait_cnt;
        PC_enable    = 1'b1;
        IF_ID_enable = 1'b1;
        ID_nop_sel   = 1'b0;
        IF_flush     = 1'b0;
        pipe_freeze  = 1'b0;
        mem_error    = 1'b0;
        run_eval     = 1'b0;
        mw_allowed   = 1'b1;

        case (state)
            RUN: run_eval = 1'b1;
            LOAD_STALL: begin
                if (mw) begin
                    pipe_freeze  = 1'b1;
                    PC_enable    = 1'b0;
                    IF_ID_enable = 1'b0;
                    bub_next     = 2'd0;
                    wait_next    = WW'(1);
                    state_next   = MEM_WAIT;
                end else begin
                    PC_enable    = 1'b0;
                    IF_ID_enable = 1'b0;
                    ID_nop_sel   = 1'b1;
                    bub_next     = bub_inc;
                    if (bub_inc == BUBBLES) begin
                        bub_next   = 2'd0;
                        state_next = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    wait_next  = '0;
                    run_eval   = 1'b1;
                    mw_allowed = 1'b0;
                end else if (wait_inc == TIMEOUT) begin
                    mem_error  = 1'b1;
                    wait_next  = '0;
                    run_eval   = 1'b1;
                    mw_allowed = 1'b0;
                end else begin
                    pipe_freeze  = 1'b1;
                    PC_enable    = 1'b0;
                    IF_ID_enable = 1'b0;
                    wait_next    = wait_inc;
                end
            end
            default: state_next = RUN;
        endcase

        if (run_eval) begin
            state_next = RUN;
            bub_next   = 2'd0;
            if (mw_allowed && mw) begin
                pipe_freeze  = 1'b1;
                PC_enable    = 1'b0;
                IF_ID_enable = 1'b0;
                wait_next    = WW'(1);
                state_next   = MEM_WAIT;
            end else if (luh) begin
                PC_enable    = 1'b0;
                IF_ID_enable = 1'b0;
                ID_nop_sel   = 1'b1;
                bub_next     = 2'd1;
                state_next   = (BUBBLES > 2'd1) ? LOAD_STALL : RUN;
            end else if (branch_taken) begin
                IF_flush = 1'b1;
            end
        end

        if (reset) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_nop_sel   = 1'b1;
            IF_flush     = 1'b1;
            pipe_freeze  = 1'b0;
            mem_error    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: three instances (1..3 load-use bubbles) share stimulus and are
// compared every cycle against a cycle-count model, plus directed literal expectations.
module tb_pipeline_hazard_sequencer;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       reset;
    logic [3:0] ID_Rn, ID_Rm, ID_Rd;
    logic       ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic       ID_B_instr, cond_true;
    logic [3:0] EX_Rd, MEM_Rd, WB_Rd;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic       EX_Load_Inst, MEM_mem_enable, mem_ready;

    logic       pc_en [3];
    logic       ifid_en [3];
    logic       nop_sel [3];
    logic       flush [3];
    logic       freeze [3];
    logic       merr [3];
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic [1:0] fc [3];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc, ifid, nop, flush, freeze, err;
        logic [1:0] fa, fb, fc;
    } exp_t;

    // Model state: remaining bubbles and elapsed wait cycles, per instance
    int bubbles_left [3];
    bit waiting [3];
    int waited [3];
    int hold_low;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_hazard_sequencer #(.LOAD_USE_BUBBLES(g + 1), .MEM_TIMEOUT(TIMEOUT)) dut (
            .clk(clk), .reset(reset),
            .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
            .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
            .ID_B_instr(ID_B_instr), .cond_true(cond_true),
            .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
            .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
            .EX_Load_Inst(EX_Load_Inst), .MEM_mem_enable(MEM_mem_enable), .mem_ready(mem_ready),
            .PC_enable(pc_en[g]), .IF_ID_enable(ifid_en[g]), .ID_nop_sel(nop_sel[g]),
            .IF_flush(flush[g]), .pipe_freeze(freeze[g]),
            .fwd_A(fa[g]), .fwd_B(fb[g]), .fwd_C(fc[g]), .mem_error(merr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [3:0] r, input logic u);
        if (!u || r == 4'd15) return 2'b00;
        if (EX_RF_enable && EX_Rd == r && !EX_Load_Inst) return 2'b01;
        if (MEM_RF_enable && MEM_Rd == r) return 2'b10;
        if (WB_RF_enable && WB_Rd == r) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit refHit(input logic [3:0] r, input logic u);
        return u && r != 4'd15 && EX_RF_enable && EX_Load_Inst && EX_Rd == r;
    endfunction

    task automatic modelStep(input int k, output exp_t e);
        bit mw, luh, do_normal, allow_mw;
        mw  = MEM_mem_enable && !mem_ready;
        luh = refHit(ID_Rn, ID_use_Rn) || refHit(ID_Rm, ID_use_Rm) || refHit(ID_Rd, ID_use_Rd);
        e = '{pc: 1'b1, ifid: 1'b1, nop: 1'b0, flush: 1'b0, freeze: 1'b0, err: 1'b0,
              fa: refFwd(ID_Rn, ID_use_Rn), fb: refFwd(ID_Rm, ID_use_Rm), fc: refFwd(ID_Rd, ID_use_Rd)};
        if (reset) begin
            e = '{pc: 1'b0, ifid: 1'b0, nop: 1'b1, flush: 1'b1, freeze: 1'b0, err: 1'b0,
                  fa: 2'b00, fb: 2'b00, fc: 2'b00};
            bubbles_left[k] = 0;
            waiting[k] = 1'b0;
            waited[k] = 0;
            return;
        end
        do_normal = 1'b0;
        allow_mw  = 1'b1;
        if (waiting[k]) begin
            if (mem_ready) begin
                waiting[k] = 1'b0; waited[k] = 0; do_normal = 1'b1; allow_mw = 1'b0;
            end else if (waited[k] + 1 == TIMEOUT) begin
                e.err = 1'b1; waiting[k] = 1'b0; waited[k] = 0; do_normal = 1'b1; allow_mw = 1'b0;
            end else begin
                e.freeze = 1'b1; e.pc = 1'b0; e.ifid = 1'b0; waited[k]++;
            end
        end else if (bubbles_left[k] > 0) begin
            if (mw) begin
                e.freeze = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
                waiting[k] = 1'b1; waited[k] = 1; bubbles_left[k] = 0;
            end else begin
                e.pc = 1'b0; e.ifid = 1'b0; e.nop = 1'b1; bubbles_left[k]--;
            end
        end else begin
            do_normal = 1'b1;
        end
        if (do_normal) begin
            if (allow_mw && mw) begin
                e.freeze = 1'b1; e.pc = 1'b0; e.ifid = 1'b0; waiting[k] = 1'b1; waited[k] = 1;
            end else if (luh) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.nop = 1'b1; bubbles_left[k] = k;
            end else if (ID_B_instr && cond_true) begin
                e.flush = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            modelStep(k, e);
            checkOutput($sformatf("dut%0d.PC_enable", k), 2'(pc_en[k]), 2'(e.pc));
            checkOutput($sformatf("dut%0d.IF_ID_enable", k), 2'(ifid_en[k]), 2'(e.ifid));
            checkOutput($sformatf("dut%0d.ID_nop_sel", k), 2'(nop_sel[k]), 2'(e.nop));
            checkOutput($sformatf("dut%0d.IF_flush", k), 2'(flush[k]), 2'(e.flush));
            checkOutput($sformatf("dut%0d.pipe_freeze", k), 2'(freeze[k]), 2'(e.freeze));
            checkOutput($sformatf("dut%0d.mem_error", k), 2'(merr[k]), 2'(e.err));
            checkOutput($sformatf("dut%0d.fwd_A", k), fa[k], e.fa);
            checkOutput($sformatf("dut%0d.fwd_B", k), fb[k], e.fb);
            checkOutput($sformatf("dut%0d.fwd_C", k), fc[k], e.fc);
        end
    end

    task automatic setIdle();
        reset = 1'b0;
        {ID_Rn, ID_Rm, ID_Rd} = '0;
        {ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_B_instr, cond_true} = '0;
        {EX_Rd, MEM_Rd, WB_Rd} = '0;
        {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_Load_Inst, MEM_mem_enable} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] randReg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    endfunction

    task automatic applyStimulus();
        reset          = ($urandom_range(0, 149) == 0);
        ID_Rn          = randReg();
        ID_Rm          = randReg();
        ID_Rd          = randReg();
        ID_use_Rn      = 1'($urandom_range(0, 1));
        ID_use_Rm      = 1'($urandom_range(0, 1));
        ID_use_Rd      = ($urandom_range(0, 3) == 0);
        ID_B_instr     = ($urandom_range(0, 3) == 0);
        cond_true      = 1'($urandom_range(0, 1));
        EX_Rd          = randReg();
        MEM_Rd         = randReg();
        WB_Rd          = randReg();
        EX_RF_enable   = 1'($urandom_range(0, 1));
        MEM_RF_enable  = 1'($urandom_range(0, 1));
        WB_RF_enable   = 1'($urandom_range(0, 1));
        EX_Load_Inst   = ($urandom_range(0, 2) == 0);
        MEM_mem_enable = ($urandom_range(0, 2) == 0);
        if (hold_low > 0) begin
            mem_ready = 1'b0;
            hold_low--;
        end else if ($urandom_range(0, 39) == 0) begin
            mem_ready = 1'b0;
            hold_low  = int'($urandom_range(10, 20));
        end else begin
            mem_ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    initial begin
        hold_low = 0;
        setIdle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset.PC_enable", 2'(pc_en[0]), 2'd0);
            checkOutput("reset.ID_nop_sel", 2'(nop_sel[0]), 2'd1);
            checkOutput("reset.IF_flush", 2'(flush[0]), 2'd1);
        end
        nextCycle(); reset = 1'b0;
        @(negedge clk);
        checkOutput("release.PC_enable", 2'(pc_en[0]), 2'd1);
        checkOutput("release.IF_flush", 2'(flush[0]), 2'd0);

        // Forwarding priority, then the same register turning into a load-use hazard
        nextCycle();
        ID_Rn = 4'd3; ID_use_Rn = 1'b1; EX_Rd = 4'd3; EX_RF_enable = 1'b1;
        MEM_Rd = 4'd3; MEM_RF_enable = 1'b1;
        @(negedge clk);
        checkOutput("fwd_ex.fwd_A", fa[0], 2'b01);
        nextCycle(); EX_Load_Inst = 1'b1;
        @(negedge clk);
        checkOutput("luh.fwd_A", fa[0], 2'b10);
        checkOutput("luh.PC_enable", 2'(pc_en[0]), 2'd0);
        checkOutput("luh.ID_nop_sel", 2'(nop_sel[0]), 2'd1);
        nextCycle(); EX_RF_enable = 1'b0; EX_Load_Inst = 1'b0;
        @(negedge clk);
        checkOutput("luh_end.PC_enable", 2'(pc_en[0]), 2'd1);
        checkOutput("luh2_hold.PC_enable", 2'(pc_en[1]), 2'd0);
        nextCycle(); setIdle();

        // Two-bubble instance on R5
        nextCycle();
        ID_Rm = 4'd5; ID_use_Rm = 1'b1; EX_Rd = 4'd5; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        @(negedge clk);
        checkOutput("luh2_c1.PC_enable", 2'(pc_en[1]), 2'd0);
        nextCycle(); EX_RF_enable = 1'b0; EX_Load_Inst = 1'b0;
        @(negedge clk);
        checkOutput("luh2_c2.ID_nop_sel", 2'(nop_sel[1]), 2'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("luh2_end.PC_enable", 2'(pc_en[1]), 2'd1);
        nextCycle(); setIdle();

        // Four-cycle memory wait, then a full timeout
        for (int i = 0; i < 4; i++) begin
            nextCycle(); MEM_mem_enable = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            checkOutput("mw.pipe_freeze", 2'(freeze[0]), 2'd1);
            checkOutput("mw.mem_error", 2'(merr[0]), 2'd0);
        end
        nextCycle(); mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("mw_ready.pipe_freeze", 2'(freeze[0]), 2'd0);
        nextCycle(); setIdle();
        for (int i = 1; i <= TIMEOUT; i++) begin
            nextCycle(); MEM_mem_enable = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            checkOutput("timeout.mem_error", 2'(merr[0]), (i == TIMEOUT) ? 2'd1 : 2'd0);
        end
        nextCycle(); setIdle();
        @(negedge clk);
        checkOutput("timeout_after.mem_error", 2'(merr[0]), 2'd0);
        checkOutput("timeout_after.PC_enable", 2'(pc_en[0]), 2'd1);

        // Taken branch alone, then together with a load-use hazard
        nextCycle(); ID_B_instr = 1'b1; cond_true = 1'b1;
        @(negedge clk);
        checkOutput("branch.IF_flush", 2'(flush[0]), 2'd1);
        nextCycle(); setIdle();
        @(negedge clk);
        checkOutput("branch_off.IF_flush", 2'(flush[0]), 2'd0);
        nextCycle();
        ID_B_instr = 1'b1; cond_true = 1'b1; ID_Rn = 4'd7; ID_use_Rn = 1'b1;
        EX_Rd = 4'd7; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        @(negedge clk);
        checkOutput("br_luh.IF_flush", 2'(flush[0]), 2'd0);
        checkOutput("br_luh.PC_enable", 2'(pc_en[0]), 2'd0);
        nextCycle(); EX_RF_enable = 1'b0; EX_Load_Inst = 1'b0;
        @(negedge clk);
        checkOutput("br_after.IF_flush", 2'(flush[0]), 2'd1);
        nextCycle(); setIdle();

        // R15 is never forwarded and never stalls
        nextCycle();
        ID_Rm = 4'd15; ID_use_Rm = 1'b1; EX_Rd = 4'd15; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        @(negedge clk);
        checkOutput("r15.fwd_B", fb[0], 2'b00);
        checkOutput("r15.PC_enable", 2'(pc_en[0]), 2'd1);
        nextCycle(); setIdle();

        // Reset in the middle of a memory wait
        nextCycle(); MEM_mem_enable = 1'b1; mem_ready = 1'b0;
        nextCycle(); reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset.pipe_freeze", 2'(freeze[0]), 2'd0);
        nextCycle(); setIdle();
        @(negedge clk);
        checkOutput("midreset_after.PC_enable", 2'(pc_en[0]), 2'd1);
        checkOutput("midreset_after.ID_nop_sel", 2'(nop_sel[0]), 2'd0);

        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            applyStimulus();
        end
        nextCycle(); setIdle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
